// File: rtl/uart_cmd_pkg.sv
// Shared opcode/response constants and FSM state encoding for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] OpWrite = 8'h57;  // 'W'
  localparam logic [7:0] OpRead  = 8'h52;  // 'R'
  localparam logic [7:0] RspOk   = 8'h4B;  // 'K'
  localparam logic [7:0] RspErr  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StExec,
    StRdWait,
    StTxReq,
    StTxStart,
    StTxDone
  } state_e;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte idle timer: counts while run is high, clears on clear or when not running.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [31:0] count_q;

  assign expired = run && (count_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || !run) begin
      count_q <= '0;
    end else if (!expired) begin
      count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART byte-command controller: 'W' addr data / 'R' addr frames drive a simple register bus.
// Optional inter-byte timeout is enabled with macro UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_received,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_recv_error,
  input  logic       uart_is_transmitting,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] err_count
);

  state_e     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] err_q, err_d;
  logic       err_inc;
  logic       timeout;

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (uart_received),
    .run    ((state_q == StGetAddr) || (state_q == StGetData)),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    tx_d          = tx_q;
    err_inc       = 1'b0;
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    uart_transmit = 1'b0;

    case (state_q)
      StIdle: begin
        if (uart_recv_error) begin
          err_inc = 1'b1;
        end else if (uart_received) begin
          if ((uart_rx_byte == OpWrite) || (uart_rx_byte == OpRead)) begin
            is_wr_d = (uart_rx_byte == OpWrite);
            state_d = StGetAddr;
          end else begin
            tx_d    = RspErr;
            state_d = StTxReq;
          end
        end
      end
      StGetAddr: begin
        if (uart_recv_error || (!uart_received && timeout)) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end else if (uart_received) begin
          addr_d  = uart_rx_byte;
          state_d = is_wr_q ? StGetData : StExec;
        end
      end
      StGetData: begin
        if (uart_recv_error || (!uart_received && timeout)) begin
          err_inc = 1'b1;
          state_d = StIdle;
        end else if (uart_received) begin
          wdata_d = uart_rx_byte;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_wr_q) begin
          reg_we  = 1'b1;
          tx_d    = RspOk;
          state_d = StTxReq;
        end else begin
          reg_re  = 1'b1;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        tx_d    = reg_rdata;
        state_d = StTxReq;
      end
      StTxReq: begin
        uart_transmit = 1'b1;
        state_d       = StTxStart;
      end
      StTxStart: begin
        uart_transmit = 1'b1;
        if (uart_is_transmitting) state_d = StTxDone;
      end
      StTxDone: begin
        // Transmit stays low here so a slow transmitter never sees a second request.
        if (!uart_is_transmitting) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  assign uart_tx_byte = tx_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign err_count    = err_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: vector table plus scoreboard queues for strobes/responses.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_received;
  logic [7:0] uart_rx_byte;
  logic       uart_recv_error;
  logic       uart_is_transmitting;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .uart_received       (uart_received),
    .uart_rx_byte        (uart_rx_byte),
    .uart_recv_error     (uart_recv_error),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_transmit       (uart_transmit),
    .uart_tx_byte        (uart_tx_byte),
    .reg_addr            (reg_addr),
    .reg_wdata           (reg_wdata),
    .reg_we              (reg_we),
    .reg_re              (reg_re),
    .reg_rdata           (reg_rdata),
    .busy                (busy),
    .err_count           (err_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  int   we_cnt = 0, re_cnt = 0, tx_cnt = 0, tx_hi_cnt = 0;
  logic prev_tx = 1'b0, re_prev = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int   tx_len = 3;

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2, rdata;
    logic       we, re;
    logic [7:0] addr, wdata, tx;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_byte  = b;
    uart_received = 1'b1;
    step();
    uart_received = 1'b0;
    repeat (2) step();
  endtask

  task automatic send_err();
    uart_recv_error = 1'b1;
    step();
    uart_recv_error = 1'b0;
    repeat (2) step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check($sformatf("%s_idle_reached", tag), busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_transmit", tag), uart_transmit, 0);
    check($sformatf("%s_tx_byte", tag), uart_tx_byte, 8'h00);
    check($sformatf("%s_reg_addr", tag), reg_addr, 8'h00);
    check($sformatf("%s_reg_wdata", tag), reg_wdata, 8'h00);
    check($sformatf("%s_reg_we", tag), reg_we, 0);
    check($sformatf("%s_reg_re", tag), reg_re, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_err_count", tag), err_count, 8'h00);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int we0 = we_cnt;
    int re0 = re_cnt;
    int tx0 = tx_cnt;
    if (v.we) exp_wr.push_back({v.addr, v.wdata});
    if (v.re) exp_rd.push_back(v.addr);
    exp_tx.push_back(v.tx);
    rd_val = v.rdata;
    send_byte(v.b0);
    if (v.nb > 1) send_byte(v.b1);
    if (v.nb > 2) send_byte(v.b2);
    wait_idle(tag);
    check($sformatf("%s_we_pulses", tag), we_cnt - we0, {31'd0, v.we});
    check($sformatf("%s_re_pulses", tag), re_cnt - re0, {31'd0, v.re});
    check($sformatf("%s_tx_count", tag), tx_cnt - tx0, 1);
  endtask

  // Scoreboard monitor; also supplies read data only in the cycle after reg_re.
  initial begin
    reg_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_we && reg_re) check("we_re_exclusive", {reg_we, reg_re}, 2'b10);
        if (reg_we) begin
          we_cnt++;
          check("we_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) check("we_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
        end
        if (reg_re) begin
          re_cnt++;
          check("re_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check("re_addr", reg_addr, exp_rd.pop_front());
        end
        if (uart_transmit && !prev_tx) begin
          tx_cnt++;
          check("tx_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) check("tx_byte", uart_tx_byte, exp_tx.pop_front());
        end
        if (uart_transmit) tx_hi_cnt++;
      end
      prev_tx   = uart_transmit;
      reg_rdata = re_prev ? rd_val : 8'hEE;
      re_prev   = reg_re;
    end
  end

  // Transmitter model: goes busy right after a request and stays busy for tx_len cycles.
  initial begin
    uart_is_transmitting = 1'b0;
    forever begin
      step();
      if (uart_transmit && !uart_is_transmitting) begin
        uart_is_transmitting = 1'b1;
        repeat (tx_len) @(posedge clk);
        #1;
        uart_is_transmitting = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int we0, tx0, hi0;

    vecs[0] = '{3, 8'h57, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h10, 8'hA5, 8'h4B};
    vecs[1] = '{2, 8'h52, 8'h22, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h22, 8'h00, 8'h3C};
    vecs[2] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3F};
    vecs[3] = '{3, 8'h57, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h4B};
    vecs[4] = '{2, 8'h52, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5};
    vecs[5] = '{1, 8'h4B, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3F};
    vecs[6] = '{2, 8'h52, 8'h7E, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7E, 8'h00, 8'h00};

    rst_n           = 1'b0;
    uart_received   = 1'b0;
    uart_rx_byte    = 8'h00;
    uart_recv_error = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Framing error during a write frame aborts it silently.
    we0 = we_cnt;
    tx0 = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    send_err();
    check("err_abort_busy", busy, 0);
    check("err_abort_count", err_count, 8'd1);
    check("err_abort_no_we", we_cnt - we0, 0);
    check("err_abort_no_tx", tx_cnt - tx0, 0);

    // Error and byte in the same cycle: error wins.
    uart_recv_error = 1'b1;
    uart_received   = 1'b1;
    uart_rx_byte    = 8'h57;
    step();
    uart_recv_error = 1'b0;
    uart_received   = 1'b0;
    check("prio_busy", busy, 0);
    check("prio_err_count", err_count, 8'd2);

    // Slow transmitter: one request, held busy, bytes ignored meanwhile.
    tx_len = 50;
    tx0    = tx_cnt;
    hi0    = tx_hi_cnt;
    exp_tx.push_back(8'h3F);
    send_byte(8'h00);
    repeat (10) step();
    check("slow_tx_busy_a", busy, 1);
    send_byte(8'h57);
    check("slow_tx_busy_b", busy, 1);
    repeat (20) step();
    check("slow_tx_busy_c", busy, 1);
    check("slow_tx_transmit_low", uart_transmit, 0);
    wait_idle("slow_tx");
    check("slow_tx_once", tx_cnt - tx0, 1);
    check("slow_tx_hi_cycles", tx_hi_cnt - hi0, 2);
    check("slow_tx_err_unchanged", err_count, 8'd2);
    tx_len = 3;
    run_vec('{2, 8'h52, 8'h5A, 8'h00, 8'h99, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h99}, "after_slow");

    // Reset in the middle of GET_DATA drops the frame.
    send_byte(8'h57);
    send_byte(8'h33);
    check("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) step();
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    step();
    run_vec('{3, 8'h57, 8'h44, 8'h66, 8'h00, 1'b1, 1'b0, 8'h44, 8'h66, 8'h4B}, "post_reset");

`ifdef UART_CMD_TIMEOUT_EN
    uart_rx_byte  = 8'h52;
    uart_received = 1'b1;
    step();
    uart_received = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      step();
    end
    check("timeout_cycles", n, 100);
    check("timeout_err_count", err_count, 8'd1);
`endif

    for (int i = 0; i < 300; i++) begin
      uart_recv_error = 1'b1;
      step();
      uart_recv_error = 1'b0;
      step();
    end
    check("err_saturate", err_count, 8'hFF);

    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
